// File: rtl/sd_dat_buffer_if.sv
// Host-side Buffer Data Port bundle for sd_dat_buffer: 32-bit write and read word handshakes.
// The master drives write data, write strobe and read acknowledge; the slave (buffer) answers.
interface sd_dat_buffer_if;
  logic [31:0] wdata_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        rready_i;

  modport master (
    output wdata_i, wvalid_i, rready_i,
    input  wready_o, rdata_o, rvalid_o
  );

  modport slave (
    input  wdata_i, wvalid_i, rready_i,
    output wready_o, rdata_o, rvalid_o
  );
endinterface

// File: rtl/sd_dat_buffer.sv
// Word FIFO between host words and the SD DAT byte stream; serialises on TX, packs on RX.
// Optional sticky underrun/overflow flags are built only when SD_DAT_BUF_ERR_EN is defined.
module sd_dat_buffer #(
  parameter int DEPTH_WORDS = 128
) (
  input  logic                           sdclk_i,
  input  logic                           rst_dat_i,
  input  logic                           dir_i,
  input  logic                           flush_i,
  input  logic [11:0]                    block_size_i,
  sd_dat_buffer_if.slave                 host,
  output logic [7:0]                     tx_data_o,
  input  logic                           tx_ready_i,
  input  logic [7:0]                     rx_data_i,
  input  logic                           rx_valid_i,
  output logic                           buf_wr_en_o,
  output logic                           buf_rd_en_o,
  output logic [$clog2(DEPTH_WORDS):0]   level_o,
  output logic                           underrun_o,
  output logic                           overflow_o
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] FULL_L = (AW + 1)'(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [1:0]    r_lane;
  logic [11:0]   r_byte_cnt;
  logic [31:0]   r_asm;

  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_head;
  logic          w_last;
  logic          w_word_end;
  logic          w_tx_adv;
  logic          w_rx_adv;
  logic          w_adv;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_push_data;
  logic [31:0]   w_rx_word;
  logic [31:0]   w_need;
  logic [31:0]   w_stored;
  logic [31:0]   w_free;

  assign w_full     = (r_level == FULL_L);
  assign w_empty    = (r_level == '0);
  assign w_head     = r_mem[r_rptr];
  assign w_last     = (r_byte_cnt == block_size_i - 12'd1);
  assign w_word_end = (r_lane == 2'd3) || w_last;
  assign w_tx_adv   = !dir_i && tx_ready_i;
  assign w_rx_adv   = dir_i && rx_valid_i;
  assign w_adv      = w_tx_adv || w_rx_adv;

  // The incoming byte lands in its lane; untouched upper lanes of the assembly are still zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rx_lane
      assign w_rx_word[8*gi +: 8] = (r_lane == 2'(gi)) ? rx_data_i : r_asm[8*gi +: 8];
    end
  endgenerate

  assign w_push      = (dir_i ? (w_rx_adv && w_word_end) : host.wvalid_i) && !w_full;
  assign w_pop       = (dir_i ? host.rready_i : (w_tx_adv && w_word_end)) && !w_empty;
  assign w_push_data = dir_i ? w_rx_word : host.wdata_i;

  assign host.wready_o = !dir_i && !w_full;
  assign host.rvalid_o = dir_i && !w_empty;
  assign host.rdata_o  = (dir_i && !w_empty) ? w_head : 32'h0;
  assign tx_data_o     = (!dir_i && !w_empty) ? w_head[8*r_lane +: 8] : 8'h00;
  assign level_o       = r_level;

  // Block-granular enables compare whole-word requirement against free or stored words.
  assign w_need      = 32'(({1'b0, block_size_i} + 13'd3) >> 2);
  assign w_stored    = 32'(r_level);
  assign w_free      = DEPTH_U - w_stored;
  assign buf_wr_en_o = !dir_i && (w_free >= w_need);
  assign buf_rd_en_o = dir_i && (w_stored >= w_need);

  always_ff @(posedge sdclk_i) begin
    if (w_push && !rst_dat_i && !flush_i) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  always_ff @(posedge sdclk_i) begin
    if (rst_dat_i || flush_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_lane     <= 2'd0;
      r_byte_cnt <= 12'd0;
      r_asm      <= 32'h0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // Lane and byte count advance even on an empty TX request so block framing stays aligned.
      if (w_adv) begin
        r_lane     <= w_word_end ? 2'd0 : r_lane + 2'd1;
        r_byte_cnt <= w_last ? 12'd0 : r_byte_cnt + 12'd1;
      end
      if (w_rx_adv) begin
        r_asm <= w_word_end ? 32'h0 : w_rx_word;
      end
    end
  end

`ifdef SD_DAT_BUF_ERR_EN
  logic r_underrun;
  logic r_overflow;

  always_ff @(posedge sdclk_i) begin
    if (rst_dat_i || flush_i) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_tx_adv && w_empty) begin
        r_underrun <= 1'b1;
      end
      if (w_rx_adv && w_word_end && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign underrun_o = r_underrun;
  assign overflow_o = r_overflow;
`else
  assign underrun_o = 1'b0;
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sd_dat_buffer.sv
// Directed self-checking bench for sd_dat_buffer with a 4-word FIFO.
// Error-flag expectations follow whether SD_DAT_BUF_ERR_EN is defined for the build.
module tb_sd_dat_buffer;

`ifdef SD_DAT_BUF_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_dat;
  logic        dir;
  logic        flush;
  logic [11:0] block_size;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        buf_wr_en;
  logic        buf_rd_en;
  logic [2:0]  level;
  logic        underrun;
  logic        overflow;

  int n_vec;
  int n_err;

  sd_dat_buffer_if host_if ();

  sd_dat_buffer #(.DEPTH_WORDS(4)) dut (
    .sdclk_i      (clk),
    .rst_dat_i    (rst_dat),
    .dir_i        (dir),
    .flush_i      (flush),
    .block_size_i (block_size),
    .host         (host_if.slave),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .buf_wr_en_o  (buf_wr_en),
    .buf_rd_en_o  (buf_rd_en),
    .level_o      (level),
    .underrun_o   (underrun),
    .overflow_o   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    host_if.wdata_i  = w;
    host_if.wvalid_i = 1'b1;
    tick();
    host_if.wvalid_i = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_dat = 1'b1;
    tick();
    tick();
    rst_dat = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", level); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    n_vec++; if (host_if.rvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b expected 0", host_if.rvalid_o); end
    n_vec++; if (host_if.rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", host_if.rdata_o); end
    n_vec++; if (host_if.wready_o !== 1'b1) begin n_err++; $display("FAIL rst_wready: got %b expected 1", host_if.wready_o); end
    n_vec++; if (buf_wr_en !== 1'b1) begin n_err++; $display("FAIL rst_buf_wr_en: got %b expected 1", buf_wr_en); end
    n_vec++; if (buf_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_buf_rd_en: got %b expected 0", buf_rd_en); end
    n_vec++; if ({underrun, overflow} !== 2'b00) begin n_err++; $display("FAIL rst_err_flags: got %b expected 00", {underrun, overflow}); end
    $display("reset: checked reset values");
  endtask

  task automatic test_write_basic();
    logic [7:0] exp_b [8];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    dir = 1'b0;
    block_size = 12'd8;
    do_flush();
    push_word(32'h44332211);
    n_vec++; if (tx_data !== 8'h11) begin n_err++; $display("FAIL wr_first_byte_latency: got %h expected 11", tx_data); end
    push_word(32'h88776655);
    n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL wr_level2: got %0d expected 2", level); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (tx_data !== exp_b[i]) begin n_err++; $display("FAIL wr_byte%0d: got %h expected %h", i, tx_data, exp_b[i]); end
      tx_ready = 1'b1;
      tick();
    end
    tx_ready = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL wr_level_drained: got %0d expected 0", level); end
    push_word(32'hCAFEBABE);
    n_vec++; if (tx_data !== 8'hBE) begin n_err++; $display("FAIL wr_lane_restart: got %h expected be", tx_data); end
    $display("write_basic: 8 bytes serialised, next word starts at lane 0");
  endtask

  task automatic test_partial_word();
    logic [7:0] exp_b [6];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    dir = 1'b0;
    block_size = 12'd6;
    do_flush();
    push_word(32'hDDCCBBAA);
    push_word(32'h4433FFEE);
    push_word(32'h0C0B0A09);
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (tx_data !== exp_b[i]) begin n_err++; $display("FAIL part_byte%0d: got %h expected %h", i, tx_data, exp_b[i]); end
      tx_ready = 1'b1;
      tick();
    end
    tx_ready = 1'b0;
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL part_level: got %0d expected 1", level); end
    n_vec++; if (tx_data !== 8'h09) begin n_err++; $display("FAIL part_next_block: got %h expected 09", tx_data); end
    $display("partial_word: 6-byte block, tail bytes discarded");
  endtask

  task automatic test_read_pack();
    dir = 1'b1;
    block_size = 12'd5;
    do_flush();
    n_vec++; if (host_if.rvalid_o !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_empty: got %b expected 0", host_if.rvalid_o); end
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(i + 1);
      tick();
      if (i == 3) begin
        n_vec++; if (host_if.rvalid_o !== 1'b1) begin n_err++; $display("FAIL rd_rvalid_word1: got %b expected 1", host_if.rvalid_o); end
        n_vec++; if (host_if.rdata_o !== 32'h04030201) begin n_err++; $display("FAIL rd_word1: got %h expected 04030201", host_if.rdata_o); end
        n_vec++; if (buf_rd_en !== 1'b0) begin n_err++; $display("FAIL rd_buf_rd_en_1word: got %b expected 0", buf_rd_en); end
      end
    end
    rx_valid = 1'b0;
    n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL rd_level2: got %0d expected 2", level); end
    n_vec++; if (buf_rd_en !== 1'b1) begin n_err++; $display("FAIL rd_buf_rd_en_2words: got %b expected 1", buf_rd_en); end
    host_if.rready_i = 1'b1;
    tick();
    n_vec++; if (host_if.rdata_o !== 32'h00000005) begin n_err++; $display("FAIL rd_word2: got %h expected 00000005", host_if.rdata_o); end
    tick();
    host_if.rready_i = 1'b0;
    n_vec++; if ({host_if.rvalid_o, level} !== 4'b0_000) begin n_err++; $display("FAIL rd_drained: got rvalid=%b level=%0d expected 0/0", host_if.rvalid_o, level); end
    $display("read_pack: 5 bytes packed into 2 words");
  endtask

  task automatic test_full_empty();
    logic [31:0] words [4];
    words = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0};
    dir = 1'b0;
    block_size = 12'd4;
    do_flush();
    for (int i = 0; i < 4; i++) begin
      push_word(words[i]);
      n_vec++; if (level !== 3'(i + 1)) begin n_err++; $display("FAIL full_level%0d: got %0d expected %0d", i, level, i + 1); end
    end
    n_vec++; if (host_if.wready_o !== 1'b0) begin n_err++; $display("FAIL full_wready: got %b expected 0", host_if.wready_o); end
    n_vec++; if (buf_wr_en !== 1'b0) begin n_err++; $display("FAIL full_buf_wr_en: got %b expected 0", buf_wr_en); end
    push_word(32'hEEEEEEEE);
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_push_ignored: got %0d expected 4", level); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (tx_data !== 8'(8'hA0 + i)) begin n_err++; $display("FAIL full_drain_byte%0d: got %h expected %h", i, tx_data, 8'(8'hA0 + i)); end
      tx_ready = 1'b1;
      tick();
    end
    tx_ready = 1'b0;
    n_vec++; if ({level, buf_wr_en} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL full_level3: got level=%0d wr_en=%b expected 3/1", level, buf_wr_en); end
    tx_ready = 1'b1;
    tick();
    tick();
    tick();
    host_if.wdata_i  = 32'hE3E2E1E0;
    host_if.wvalid_i = 1'b1;
    tick();
    host_if.wvalid_i = 1'b0;
    tx_ready = 1'b0;
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL full_push_pop_level: got %0d expected 3", level); end
    n_vec++; if (tx_data !== 8'hC0) begin n_err++; $display("FAIL full_push_pop_head: got %h expected c0", tx_data); end
    $display("full_empty: full stops pushes, push+pop holds level");
  endtask

  task automatic test_errors();
    dir = 1'b0;
    block_size = 12'd4;
    do_flush();
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL err_empty_tx: got %h expected 00", tx_data); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_vec++; if (underrun !== ERR_ON) begin n_err++; $display("FAIL err_underrun_set: got %b expected %b", underrun, ERR_ON); end
    push_word(32'h44332211);
    n_vec++; if (tx_data !== 8'h22) begin n_err++; $display("FAIL err_lane_advanced: got %h expected 22", tx_data); end
    do_flush();
    n_vec++; if ({underrun, level} !== 4'b0_000) begin n_err++; $display("FAIL err_underrun_flush: got underrun=%b level=%0d expected 0/0", underrun, level); end
    dir = 1'b1;
    block_size = 12'd16;
    do_flush();
    rx_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      rx_data = 8'(i);
      tick();
    end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL err_overflow_early: got %b expected 0", overflow); end
    n_vec++; if (buf_rd_en !== 1'b1) begin n_err++; $display("FAIL err_buf_rd_en_full: got %b expected 1", buf_rd_en); end
    rx_data = 8'h13;
    tick();
    rx_valid = 1'b0;
    n_vec++; if (overflow !== ERR_ON) begin n_err++; $display("FAIL err_overflow_set: got %b expected %b", overflow, ERR_ON); end
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL err_overflow_level: got %0d expected 4", level); end
    n_vec++; if (host_if.rdata_o !== 32'h03020100) begin n_err++; $display("FAIL err_overflow_head: got %h expected 03020100", host_if.rdata_o); end
    do_flush();
    n_vec++; if ({overflow, host_if.rvalid_o} !== 2'b00) begin n_err++; $display("FAIL err_overflow_flush: got %b expected 00", {overflow, host_if.rvalid_o}); end
    dir = 1'b0;
    do_flush();
    $display("errors: underrun and overflow exercised (flags enabled=%0d)", ERR_ON);
  endtask

  task automatic test_flush_reset();
    dir = 1'b0;
    block_size = 12'd8;
    do_flush();
    push_word(32'h13121110);
    push_word(32'h17161514);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_vec++; if (tx_data !== 8'h11) begin n_err++; $display("FAIL fl_mid_block: got %h expected 11", tx_data); end
    flush = 1'b1;
    host_if.wdata_i  = 32'h99999999;
    host_if.wvalid_i = 1'b1;
    tick();
    flush = 1'b0;
    host_if.wvalid_i = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL fl_level: got %0d expected 0", level); end
    push_word(32'h23222120);
    n_vec++; if ({level, tx_data} !== {3'd1, 8'h20}) begin n_err++; $display("FAIL fl_after: got level=%0d tx=%h expected 1/20", level, tx_data); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    rst_dat = 1'b1;
    tick();
    rst_dat = 1'b0;
    n_vec++; if ({level, tx_data} !== {3'd0, 8'h00}) begin n_err++; $display("FAIL rst_mid_level_tx: got level=%0d tx=%h expected 0/00", level, tx_data); end
    n_vec++; if ({host_if.wready_o, buf_wr_en, buf_rd_en, host_if.rvalid_o} !== 4'b1100) begin
      n_err++; $display("FAIL rst_mid_flags: got %b expected 1100", {host_if.wready_o, buf_wr_en, buf_rd_en, host_if.rvalid_o});
    end
    push_word(32'h33323130);
    n_vec++; if (tx_data !== 8'h30) begin n_err++; $display("FAIL rst_mid_lane: got %h expected 30", tx_data); end
    $display("flush_reset: flush beats push, reset clears mid-block state");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_dat = 1'b1;
    dir = 1'b0;
    flush = 1'b0;
    block_size = 12'd8;
    tx_ready = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    host_if.wdata_i  = 32'h0;
    host_if.wvalid_i = 1'b0;
    host_if.rready_i = 1'b0;
    test_reset();
    test_write_basic();
    test_partial_word();
    test_read_pack();
    test_full_empty();
    test_errors();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
